gol_gen_sequencer: RTL and testbench
====================================

Name: gol_gen_sequencer

Overview:
- Drives the previous-state row register file through one Game of Life generation per start request.
- Walks the row address, reads the three-row window (above, current, below), and computes each next row with the toroidal life rule.
- Writes results back, deferring writes so that no row is overwritten while a later row still needs its old value.
- While idle, the host load/display port is passed through to the register file.

Parameters:
- WIDTH, 8: cells per row, equal to the register file word width.
- REGBITS, 3: row address bits. N = 2**REGBITS rows. REGBITS >= 2.

Ports:
- ph1  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request one generation; sampled only in IDLE.
- host_ra  in  REGBITS  host row address, used in IDLE only.
- host_we  in  1  host write enable, used in IDLE only.
- host_wd  in  WIDTH  host write data.
- row_a  in  WIDTH  register file row ra-1 (mod N).
- row  in  WIDTH  register file row ra.
- row_b  in  WIDTH  register file row ra+1 (mod N).
- ra  out  REGBITS  row address to the register file.
- regwrite  out  1  register file write enable.
- wd  out  WIDTH  register file write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a generation completes.
- stable  out  1  valid from done onward; 1 = the last generation changed no cell.
- gen_count  out  16  completed generations, wraps at 2**16.

Behaviour:
- Reset values: IDLE, r=0, nxt0=pend=calc=0, done=0, stable=0, gen_count=0. Register file contents are not cleared.
- ra, regwrite and wd are combinational from state and registers.
- IDLE: ra=host_ra, regwrite=host_we, wd=host_wd. If start=1, go to CALC with r=0 and clear the diff flag.
- Life rule f: computed on the current window.
  - Column c neighbours are c-1 and c+1 mod WIDTH, across row_a, row and row_b: 8 neighbours.
  - Count is 4 bits.
  - Next cell = (count==3) | (row[c] & count==2).
- CALC(r): ra=r, regwrite=0.
  - r==0: nxt0<=f; r<=1; stay in CALC.
  - r==1: pend<=f; r<=2; stay in CALC.
  - r>=2: calc<=f; go to WB.
  - In every case, diff |= (f != row).
- WB: ra=r-1, regwrite=1, wd=pend; then pend<=calc.
  - r==N-1: go to WBL.
  - Otherwise r<=r+1 and go to CALC.
- WBL: ra=N-1, regwrite=1, wd=pend; go to WB0.
- WB0: ra=0, regwrite=1, wd=nxt0; go to DONE.
- DONE: done=1, stable<=~diff, gen_count<=gen_count+1; go to IDLE.
- Write ordering guarantees:
  - Row 0 is written last, so the rows N-1 and 0 windows see the old row 0.
  - Row r-1 is written only after CALC(r) has read it.
- Latency: start sampled in IDLE at cycle 0. CALC(0) at cycle 1. WB0 at cycle 2N. done at cycle 2N+1. IDLE at cycle 2N+2.
- Back-to-back: a start held high begins the next generation at cycle 2N+2.
- Busy handling: start, host_we, host_ra and host_wd are ignored while busy. regwrite never follows host_we outside IDLE.
- reset mid-generation: next cycle is IDLE with busy=0 and done=0. gen_count=0 and stable=0. Partially written rows remain as written.
- Reset has priority over start in the same cycle.

Test Plan (WIDTH=8, REGBITS=3, behavioural model of the register file, rows loaded via the host port):
- Vertical blinker, rows 2,3,4 = 8'h08, other rows 0. Pulse start:
  - done at cycle 17 exactly.
  - Afterwards row 3 = 8'h1C and all other rows = 0.
  - stable=0, gen_count=1.
- Block, rows 1,2 = 8'h18. One generation -> all rows unchanged, stable=1.
- Wrap blinker, row 0 = 8'h83 (bits 7,0,1). One generation -> rows 7, 0, 1 = 8'h01 and all others 0.
- Empty board. One generation -> all rows 0, stable=1, gen_count increments.
- Vertical blinker, start held high for two generations:
  - Second generation starts at cycle 18; second done at cycle 35.
  - Board returns to rows 2,3,4 = 8'h08; gen_count=2.
  - host_we=1 with host_wd=8'hFF pulsed at cycle 5 -> regwrite follows state only; no 8'hFF row appears.
- reset asserted at cycle 6 of a generation -> cycle 7: busy=0, done=0, gen_count=0. Then start -> a normal 17-cycle generation.

Source files
------------

// File: rtl/gol_gen_sequencer.sv
// gol_gen_sequencer
//
// Purpose:
//   Runs one Game of Life generation over an external row register file
//   per start request. Each row is computed from its three-row window
//   (above, current, below) with toroidal wrap in both directions, and
//   the results are written back. Writes trail the reads so that no row
//   is overwritten while a later window still needs its old value. While
//   idle, the host load/display port drives the register file directly.
//
// Request handshake:
//   start is a level-sensitive request. It is sampled only in IDLE, and
//   each sample starts exactly one generation. When a generation
//   finishes, done pulses for one cycle and the block returns to IDLE.
//   busy is high from the first CALC cycle through DONE. While busy,
//   start and every host_* input are ignored.
//
// Ports:
//   ph1        clock (rising edge)
//   reset      synchronous, active-high
//   start      generation request, sampled in IDLE
//   host_ra    host row address (IDLE only)
//   host_we    host write enable (IDLE only)
//   host_wd    host write data (IDLE only)
//   row_a      register file row ra-1 (mod N)
//   row        register file row ra
//   row_b      register file row ra+1 (mod N)
//   ra         row address to the register file
//   regwrite   register file write enable
//   wd         register file write data
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the DONE state
//   stable     1 = the last generation changed no cell (valid from done)
//   gen_count  completed generations, wraps at 2**16
//   state_dbg  current FSM state encoding (debug observation)

module gol_gen_sequencer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               start,
  input  logic [REGBITS-1:0] host_ra,
  input  logic               host_we,
  input  logic [WIDTH-1:0]   host_wd,
  input  logic [WIDTH-1:0]   row_a,
  input  logic [WIDTH-1:0]   row,
  input  logic [WIDTH-1:0]   row_b,
  output logic [REGBITS-1:0] ra,
  output logic               regwrite,
  output logic [WIDTH-1:0]   wd,
  output logic               busy,
  output logic               done,
  output logic               stable,
  output logic [15:0]        gen_count,
  output logic [2:0]         state_dbg
);

  localparam logic [REGBITS-1:0] LAST_ROW = {REGBITS{1'b1}};
  localparam logic [REGBITS-1:0] ROW_ONE  = REGBITS'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    WB   = 3'd2,
    WBL  = 3'd3,
    WB0  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [REGBITS-1:0] r;
  logic [WIDTH-1:0]   nxt0;      // next row 0, held until the very last write
  logic [WIDTH-1:0]   pend;      // next row r-1, waiting for its write slot
  logic [WIDTH-1:0]   calc;      // next row r, computed in CALC(r>=2)
  logic               diff;      // some cell changed during this generation
  logic               stable_q;
  logic [WIDTH-1:0]   f;

  // Life rule on one three-row window. Columns wrap at the row edges.
  function automatic logic [WIDTH-1:0] life(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] m,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] nxt;
    logic [3:0]       cnt;
    int               lc;
    int               rc;
    nxt = '0;
    for (int c = 0; c < WIDTH; c++) begin
      lc  = (c == 0) ? WIDTH - 1 : c - 1;
      rc  = (c == WIDTH - 1) ? 0 : c + 1;
      cnt = 4'(a[lc]) + 4'(a[c]) + 4'(a[rc]) +
            4'(m[lc]) + 4'(m[rc]) +
            4'(b[lc]) + 4'(b[c]) + 4'(b[rc]);
      nxt[c] = (cnt == 4'd3) | (m[c] & (cnt == 4'd2));
    end
    return nxt;
  endfunction

  assign f = life(row_a, row, row_b);

  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      nxt0      <= '0;
      pend      <= '0;
      calc      <= '0;
      diff      <= 1'b0;
      stable_q  <= 1'b0;
      gen_count <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            r    <= '0;
            diff <= 1'b0;
          end
        end
        CALC: begin
          diff <= diff | (f != row);
          if (r == '0) begin
            nxt0 <= f;
            r    <= ROW_ONE;
          end else if (r == ROW_ONE) begin
            pend <= f;
            r    <= REGBITS'(2);
          end else begin
            calc <= f;
          end
        end
        WB: begin
          pend <= calc;
          if (r != LAST_ROW) r <= r + ROW_ONE;
        end
        DONE: begin
          stable_q  <= ~diff;
          gen_count <= gen_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Next state and register file controls. Row 0 is written last so that
  // the windows of rows N-1 and 0 both see its old value; row r-1 is only
  // written in WB(r), after CALC(r) has read it as row_a.
  always_comb begin
    state_n  = state;
    ra       = r;
    regwrite = 1'b0;
    wd       = pend;
    case (state)
      IDLE: begin
        ra       = host_ra;
        regwrite = host_we;
        wd       = host_wd;
        if (start) state_n = CALC;
      end
      CALC: begin
        ra = r;
        if (r != '0 && r != ROW_ONE) state_n = WB;
      end
      WB: begin
        ra       = r - ROW_ONE;
        regwrite = 1'b1;
        wd       = pend;
        state_n  = (r == LAST_ROW) ? WBL : CALC;
      end
      WBL: begin
        ra       = LAST_ROW;
        regwrite = 1'b1;
        wd       = pend;
        state_n  = WB0;
      end
      WB0: begin
        ra       = '0;
        regwrite = 1'b1;
        wd       = nxt0;
        state_n  = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  // The registered flag only updates at the end of DONE, so the DONE cycle
  // itself presents the fresh value.
  assign stable    = done ? ~diff : stable_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// tb_gol_gen_sequencer
//
// Directed bench for gol_gen_sequencer with WIDTH=8, REGBITS=3. A
// behavioural register file serves the three-row window and takes writes.
// Boards are loaded and read back through the host port; expected rows
// are queued in exp_q and popped as each row is read back.

module tb_gol_gen_sequencer;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int N       = 8;

  logic         ph1 = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   host_ra;
  logic         host_we;
  logic [7:0]   host_wd;
  logic [7:0]   row_a, row, row_b;
  logic [2:0]   ra;
  logic         regwrite;
  logic [7:0]   wd;
  logic         busy, done, stable;
  logic [15:0]  gen_count;
  logic [2:0]   state_dbg;

  // ---------------- clock / reset ----------------
  always #5 ph1 = ~ph1;

  gol_gen_sequencer #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .ph1(ph1), .reset(reset), .start(start),
    .host_ra(host_ra), .host_we(host_we), .host_wd(host_wd),
    .row_a(row_a), .row(row), .row_b(row_b),
    .ra(ra), .regwrite(regwrite), .wd(wd),
    .busy(busy), .done(done), .stable(stable),
    .gen_count(gen_count), .state_dbg(state_dbg)
  );

  // ---------------- register file model ----------------
  logic [7:0] mem [N];
  logic [2:0] ra_m, ra_p;
  assign ra_m  = ra - 3'd1;
  assign ra_p  = ra + 3'd1;
  assign row_a = mem[ra_m];
  assign row   = mem[ra];
  assign row_b = mem[ra_p];
  always @(posedge ph1) if (regwrite) mem[ra] <= wd;

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic load_board(input logic [63:0] b);
    for (int i = 0; i < N; i++) begin
      host_ra = 3'(i);
      host_we = 1'b1;
      host_wd = b[8*i +: 8];
      @(posedge ph1); #1;
    end
    host_we = 1'b0;
  endtask

  task automatic expect_board(input string tag, input logic [63:0] b);
    for (int i = 0; i < N; i++) exp_q.push_back(b[8*i +: 8]);
    for (int i = 0; i < N; i++) begin
      host_ra = 3'(i);
      #1;
      check($sformatf("%s_row%0d", tag, i), 32'(row), 32'(exp_q.pop_front()));
    end
  endtask

  // One generation from a start pulse; checks the done cycle and the
  // return to IDLE one cycle later.
  task automatic run_gen(input string tag, input logic exp_stable);
    int cyc;
    start = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge ph1); #1;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'd17);
    check({tag, "_stable_at_done"}, 32'(stable), 32'(exp_stable));
    @(posedge ph1); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_stable"}, 32'(stable), 32'(exp_stable));
  endtask

  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0018_1800;
  localparam logic [63:0] WRAP_IN = 64'h0000_0000_0000_0083;
  localparam logic [63:0] WRAP_OT = 64'h0100_0000_0000_0101;
  localparam logic [63:0] EMPTY   = 64'h0;

  initial begin
    int cyc, d1, d2;
    reset   = 1'b1;
    start   = 1'b0;
    host_we = 1'b0;
    host_ra = '0;
    host_wd = '0;
    repeat (2) @(posedge ph1);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_gen_count", 32'(gen_count), 32'd0);
    check("reset_stable", 32'(stable), 32'd0);
    reset = 1'b0;

    // idle passthrough of the host port
    host_ra = 3'd5; host_we = 1'b1; host_wd = 8'h5A;
    #1;
    check("idle_regwrite", 32'(regwrite), 32'd1);
    check("idle_ra", 32'(ra), 32'd5);
    check("idle_wd", 32'(wd), 32'h5A);
    host_we = 1'b0;
    @(posedge ph1); #1;

    // vertical blinker
    load_board(BLINK_V);
    run_gen("blink", 1'b0);
    check("blink_gen_count", 32'(gen_count), 32'd1);
    expect_board("blink", BLINK_H);

    // still life
    load_board(BLOCK);
    run_gen("block", 1'b1);
    check("block_gen_count", 32'(gen_count), 32'd2);
    expect_board("block", BLOCK);

    // blinker across the column and row wrap
    load_board(WRAP_IN);
    run_gen("wrap", 1'b0);
    check("wrap_gen_count", 32'(gen_count), 32'd3);
    expect_board("wrap", WRAP_OT);

    // empty board
    load_board(EMPTY);
    run_gen("empty", 1'b1);
    check("empty_gen_count", 32'(gen_count), 32'd4);
    expect_board("empty", EMPTY);

    // start held high: two back-to-back generations, host write while busy
    load_board(BLINK_V);
    start = 1'b1;
    @(posedge ph1); #1;
    cyc = 1; d1 = 0; d2 = 0;
    while (cyc < 60) begin
      if (cyc == 5) begin
        host_ra = 3'd3; host_wd = 8'hFF; host_we = 1'b1;
        #1;
        check("b2b_regwrite_busy", 32'(regwrite), 32'd0);
      end
      if (cyc == 6) host_we = 1'b0;
      if (cyc == 18) check("b2b_idle_between", 32'(busy), 32'd0);
      if (done) begin
        if (d1 == 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
          break;
        end
      end
      @(posedge ph1); #1;
      cyc++;
    end
    start = 1'b0;
    check("b2b_first_done", 32'(d1), 32'd17);
    check("b2b_second_done", 32'(d2), 32'd35);
    @(posedge ph1); #1;
    check("b2b_busy", 32'(busy), 32'd0);
    check("b2b_gen_count", 32'(gen_count), 32'd6);
    check("b2b_stable", 32'(stable), 32'd0);
    expect_board("b2b", BLINK_V);

    // reset in the middle of a generation
    start = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(posedge ph1); #1;
    end
    reset = 1'b1;
    @(posedge ph1); #1;
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_gen_count", 32'(gen_count), 32'd0);
    check("midrst_stable", 32'(stable), 32'd0);
    load_board(BLINK_V);
    run_gen("after_rst", 1'b0);
    check("after_rst_gen_count", 32'(gen_count), 32'd1);
    expect_board("after_rst", BLINK_H);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
